// File: rtl/game_pkg.sv
// Shared screen geometry, game_state encodings and small helpers used by the
// game-logic blocks.
package game_pkg;

   localparam logic [9:0]  H_ACTIVE = 10'd640;
   localparam logic [9:0]  V_ACTIVE = 10'd480;
   localparam logic [9:0]  SHIP_W   = 10'd50;
   localparam logic [9:0]  SHIP_H   = 10'd20;
   localparam logic [9:0]  ROCKET_W = 10'd16;
   localparam logic [9:0]  ROCKET_H = 10'd16;

   // Launch point sits just ahead of the ship nose; the limit keeps the whole
   // 16-pixel rocket box inside the visible area.
   localparam logic [9:0]  ROCKET_LAUNCH_DX = 10'd33;
   localparam logic [10:0] ROCKET_X_LIMIT   = 11'd632;
   localparam logic [10:0] ROCKET_HALF      = 11'd8;
   localparam logic [11:0] ROCKET_RGB       = 12'h0F0;

   typedef enum logic [1:0] {
      GS_TITLE   = 2'b00,
      GS_PLAYING = 2'b01,
      GS_OVER    = 2'b10,
      GS_PAUSED  = 2'b11
   } game_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus tick-based debouncer for a raw push button;
// outputs the accepted level and a one-clk rise pulse.
module btn_debounce #(
   parameter int DEBOUNCE = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          accept_s;

   // Level flips on the tick that completes DEBOUNCE consecutive disagreements.
   always_comb begin
      accept_s = tick && (sync2_r != level_r) && (cnt_r == CW'(DEBOUNCE - 1));
   end

   // Synchronizer, disagreement counter and accepted level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         if (tick) begin
            if (sync2_r != level_r) begin
               if (accept_s) begin
                  level_r <= sync2_r;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end else begin
               cnt_r <= '0;
            end
         end
      end
   end

   // Rise is issued on the accepting tick itself so consumers acting on tick
   // edges see it on the same edge.
   assign level = level_r;
   assign rise  = accept_s && sync2_r;

endmodule

// File: rtl/rocket_ctrl.sv
// Player rocket: debounced fire launches a rocket from the ship, it flies
// right each ms tick until hit or off-screen, then a cooldown blocks re-fire.
module rocket_ctrl
   import game_pkg::*;
#(
   parameter int SPEED    = 4,
   parameter int COOLDOWN = 250,
   parameter int DEBOUNCE = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1ms,
   input  logic        fire_btn,
   input  logic [1:0]  game_state,
   input  logic [9:0]  x_ship,
   input  logic [9:0]  y_ship,
   input  logic        hit,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [9:0]  x_rocket,
   output logic [9:0]  y_rocket,
   output logic        rocket_active,
   output logic        rocket_on,
   output logic [11:0] rgb_rocket,
   output logic [7:0]  shots_fired
);

   localparam int CCW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLYING   = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   state_e         state_r;
   state_e         state_next_s;
   logic [9:0]     x_rocket_r;
   logic [9:0]     y_rocket_r;
   logic [7:0]     shots_r;
   logic [CCW-1:0] cool_cnt_r;
   logic           fire_level_s;
   logic           fire_rise_s;
   logic           fire_req_s;
   logic           playing_s;
   logic [10:0]    x_adv_s;
   logic           off_edge_s;
   logic           active_s;
   logic           in_x_s;
   logic           in_y_s;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_fire_db (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_1ms),
      .btn   (fire_btn),
      .level (fire_level_s),
      .rise  (fire_rise_s)
   );

   // A request is a 0->1 of the accepted level; level_r still reads 0 on that edge.
   always_comb begin
      fire_req_s = fire_rise_s && !fire_level_s;
      playing_s  = (game_state == GS_PLAYING);
      x_adv_s    = {1'b0, x_rocket_r} + 11'(SPEED);
      off_edge_s = (x_adv_s >= ROCKET_X_LIMIT);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: leaving play wins immediately, everything else waits for a tick.
   always_comb begin
      state_next_s = state_r;
      if (!playing_s) begin
         state_next_s = ST_IDLE;
      end else if (tick_1ms) begin
         case (state_r)
            ST_IDLE:     state_next_s = fire_req_s ? ST_FLYING : ST_IDLE;
            ST_FLYING:   state_next_s = (hit || off_edge_s) ? ST_COOLDOWN : ST_FLYING;
            ST_COOLDOWN: state_next_s = (cool_cnt_r == CCW'(COOLDOWN - 1)) ? ST_IDLE : ST_COOLDOWN;
            default:     state_next_s = ST_IDLE;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Output decode.
   always_comb begin
      case (state_r)
         ST_FLYING: active_s = 1'b1;
         default:   active_s = 1'b0;
      endcase
   end

   // Rocket position, launch counter and cooldown counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_rocket_r <= 10'd0;
         y_rocket_r <= 10'd0;
         shots_r    <= 8'd0;
         cool_cnt_r <= '0;
      end else begin
         if (state_next_s == ST_FLYING) begin
            if (state_r == ST_IDLE) begin
               x_rocket_r <= x_ship + ROCKET_LAUNCH_DX;
               y_rocket_r <= y_ship;
               shots_r    <= sat_inc8(shots_r);
            end else if (tick_1ms) begin
               x_rocket_r <= x_adv_s[9:0];
            end
         end else begin
            x_rocket_r <= 10'd0;
            y_rocket_r <= 10'd0;
         end
         if ((state_r == ST_COOLDOWN) && (state_next_s == ST_COOLDOWN)) begin
            if (tick_1ms) begin
               cool_cnt_r <= cool_cnt_r + CCW'(1);
            end
         end else begin
            cool_cnt_r <= '0;
         end
      end
   end

   // Box test widened to 11 bits so a rocket near the top edge does not wrap.
   always_comb begin
      in_x_s = (({1'b0, x} + ROCKET_HALF) >= {1'b0, x_rocket_r}) &&
               ({1'b0, x} <= ({1'b0, x_rocket_r} + ROCKET_HALF));
      in_y_s = (({1'b0, y} + ROCKET_HALF) >= {1'b0, y_rocket_r}) &&
               ({1'b0, y} <= ({1'b0, y_rocket_r} + ROCKET_HALF));
   end

   assign x_rocket      = x_rocket_r;
   assign y_rocket      = y_rocket_r;
   assign rocket_active = active_s;
   assign rocket_on     = active_s && in_x_s && in_y_s;
   assign rgb_rocket    = ROCKET_RGB;
   assign shots_fired   = shots_r;

endmodule

// File: tb/tb_rocket_ctrl.sv
// Directed bench for rocket_ctrl: launch, bounce rejection, hit, cooldown
// boundaries, edge retirement, game_state abort and reset.
module tb_rocket_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick_1ms = 1'b0;
   logic        fire_btn = 1'b0;
   logic [1:0]  game_state = 2'b00;
   logic [9:0]  x_ship = 10'd0;
   logic [9:0]  y_ship = 10'd0;
   logic        hit = 1'b0;
   logic [9:0]  x = 10'd0;
   logic [9:0]  y = 10'd0;
   logic [9:0]  x_rocket;
   logic [9:0]  y_rocket;
   logic        rocket_active;
   logic        rocket_on;
   logic [11:0] rgb_rocket;
   logic [7:0]  shots_fired;

   int checks = 0;
   int errors = 0;

   rocket_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .tick_1ms      (tick_1ms),
      .fire_btn      (fire_btn),
      .game_state    (game_state),
      .x_ship        (x_ship),
      .y_ship        (y_ship),
      .hit           (hit),
      .x             (x),
      .y             (y),
      .x_rocket      (x_rocket),
      .y_rocket      (y_rocket),
      .rocket_active (rocket_active),
      .rocket_on     (rocket_on),
      .rgb_rocket    (rgb_rocket),
      .shots_fired   (shots_fired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One tick every four clocks; returns on a negedge with tick low.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) tick_1ms = 1'b1;
         @(negedge clk) tick_1ms = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   // Change the button, let it cross the synchronizer, then debounce it.
   task automatic set_btn(input logic v);
      fire_btn = v;
      clks(3);
      ticks(10);
   endtask

   task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py, input logic exp);
      x = px;
      y = py;
      #1;
      check(tag, {15'd0, rocket_on}, {15'd0, exp});
   endtask

   initial begin
      clks(3);
      reset = 1'b0;
      clks(1);
      check("rst_x", {6'd0, x_rocket}, 16'd0);
      check("rst_y", {6'd0, y_rocket}, 16'd0);
      check("rst_active", {15'd0, rocket_active}, 16'd0);
      check("rst_shots", {8'd0, shots_fired}, 16'd0);
      check("rgb", {4'd0, rgb_rocket}, 16'h00F0);

      // Press held: launch on the 10th counted tick at (113,240).
      game_state = 2'b01;
      x_ship = 10'd80;
      y_ship = 10'd240;
      fire_btn = 1'b1;
      clks(3);
      ticks(9);
      check("pre_launch", {15'd0, rocket_active}, 16'd0);
      ticks(1);
      check("launch_active", {15'd0, rocket_active}, 16'd1);
      check("launch_x", {6'd0, x_rocket}, 16'd113);
      check("launch_y", {6'd0, y_rocket}, 16'd240);
      check("launch_shots", {8'd0, shots_fired}, 16'd1);
      ticks(2);
      check("fly_x121", {6'd0, x_rocket}, 16'd121);
      fire_btn = 1'b0;
      clks(3);
      ticks(46);
      check("fly_x305", {6'd0, x_rocket}, 16'd305);
      check("fly_y_held", {6'd0, y_rocket}, 16'd240);
      pix("on_left_top", 10'd297, 10'd232, 1'b1);
      pix("off_left", 10'd296, 10'd240, 1'b0);
      pix("on_right_bot", 10'd313, 10'd248, 1'b1);
      pix("off_bot", 10'd305, 10'd249, 1'b0);

      // Hit at 305 parks the rocket; cooldown tick 0.
      hit = 1'b1;
      ticks(1);
      hit = 1'b0;
      check("hit_active", {15'd0, rocket_active}, 16'd0);
      check("hit_x", {6'd0, x_rocket}, 16'd0);
      check("hit_y", {6'd0, y_rocket}, 16'd0);
      ticks(90);
      set_btn(1'b1);
      check("cd100_discard", {15'd0, rocket_active}, 16'd0);
      set_btn(1'b0);
      ticks(130);
      set_btn(1'b1);
      check("cd250_discard", {15'd0, rocket_active}, 16'd0);
      check("cd250_shots", {8'd0, shots_fired}, 16'd1);
      set_btn(1'b0);
      set_btn(1'b1);
      check("relaunch_active", {15'd0, rocket_active}, 16'd1);
      check("relaunch_x", {6'd0, x_rocket}, 16'd113);
      check("relaunch_shots", {8'd0, shots_fired}, 16'd2);

      // Uninterrupted flight retires at 629.
      fire_btn = 1'b0;
      clks(3);
      ticks(128);
      check("fly_x625", {6'd0, x_rocket}, 16'd625);
      ticks(1);
      check("fly_x629", {6'd0, x_rocket}, 16'd629);
      check("fly_629_active", {15'd0, rocket_active}, 16'd1);
      ticks(1);
      check("edge_retire", {15'd0, rocket_active}, 16'd0);
      check("edge_x", {6'd0, x_rocket}, 16'd0);

      // Request completing on cooldown tick 251 launches.
      ticks(241);
      fire_btn = 1'b1;
      clks(3);
      ticks(9);
      check("cd250_idle", {15'd0, rocket_active}, 16'd0);
      ticks(1);
      check("cd251_launch", {15'd0, rocket_active}, 16'd1);
      check("cd251_shots", {8'd0, shots_fired}, 16'd3);

      // Hit and edge on the same tick.
      fire_btn = 1'b0;
      clks(3);
      ticks(129);
      check("both_x629", {6'd0, x_rocket}, 16'd629);
      hit = 1'b1;
      ticks(1);
      check("both_retire", {15'd0, rocket_active}, 16'd0);
      ticks(1);
      hit = 1'b0;
      check("cd_hit_ignored", {15'd0, rocket_active}, 16'd0);
      check("both_shots", {8'd0, shots_fired}, 16'd3);

      // Leaving play clears cooldown; a new request launches at once.
      @(negedge clk) game_state = 2'b10;
      @(negedge clk) game_state = 2'b01;
      set_btn(1'b1);
      check("gs_cd_clear", {15'd0, rocket_active}, 16'd1);
      check("gs_cd_shots", {8'd0, shots_fired}, 16'd4);

      // game_state drop between ticks parks on the next clk.
      ticks(2);
      check("abort_x121", {6'd0, x_rocket}, 16'd121);
      @(negedge clk) game_state = 2'b10;
      @(negedge clk);
      check("abort_active", {15'd0, rocket_active}, 16'd0);
      check("abort_x", {6'd0, x_rocket}, 16'd0);
      check("abort_y", {6'd0, y_rocket}, 16'd0);
      game_state = 2'b01;

      // Reset mid-flight, between ticks.
      set_btn(1'b0);
      set_btn(1'b1);
      check("pre_rst_shots", {8'd0, shots_fired}, 16'd5);
      ticks(2);
      @(negedge clk) begin
         reset = 1'b1;
         fire_btn = 1'b0;
      end
      @(negedge clk);
      check("midrst_active", {15'd0, rocket_active}, 16'd0);
      check("midrst_x", {6'd0, x_rocket}, 16'd0);
      check("midrst_y", {6'd0, y_rocket}, 16'd0);
      check("midrst_shots", {8'd0, shots_fired}, 16'd0);
      reset = 1'b0;

      // Bounce every 3 ticks for 30 ticks never launches.
      for (int i = 0; i < 5; i++) begin
         fire_btn = 1'b1;
         ticks(3);
         fire_btn = 1'b0;
         ticks(3);
      end
      ticks(12);
      check("bounce_active", {15'd0, rocket_active}, 16'd0);
      check("bounce_shots", {8'd0, shots_fired}, 16'd0);

      // Launch past the edge, near the top: one tick of flight, no y wrap.
      x_ship = 10'd600;
      y_ship = 10'd3;
      set_btn(1'b1);
      check("edge_launch_x", {6'd0, x_rocket}, 16'd633);
      check("edge_launch_y", {6'd0, y_rocket}, 16'd3);
      pix("top_on_y0", 10'd633, 10'd0, 1'b1);
      pix("top_off_wrap", 10'd633, 10'd1020, 1'b0);
      pix("on_x641", 10'd641, 10'd11, 1'b1);
      pix("off_x642", 10'd642, 10'd3, 1'b0);
      pix("on_x625", 10'd625, 10'd3, 1'b1);
      pix("off_x624", 10'd624, 10'd3, 1'b0);
      ticks(1);
      check("edge_launch_retire", {15'd0, rocket_active}, 16'd0);
      check("edge_launch_shots", {8'd0, shots_fired}, 16'd1);
      pix("parked_off", 10'd0, 10'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rocket_ctrl.md
ROCKET_CTRL -- requirements
Module: rocket_ctrl

Interface
REQ-001 SHALL have parameters: SPEED, default 4, pixels advanced per tick; COOLDOWN, default 250, ticks before re-fire; DEBOUNCE, default 10, stable ticks to accept button.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 tick_1ms  in  1  one-clk-wide enable pulse, once per ms.
REQ-005 fire_btn  in  1  raw, asynchronous fire button, active-high.
REQ-006 game_state  in  2  2'b01 = playing; all other values = not playing.
REQ-007 x_ship, y_ship  in  10 each  ship centre.
REQ-008 hit  in  1  asteroid block reports rocket consumed; level, sampled on tick.
REQ-009 x, y  in  10 each  current pixel.
REQ-010 x_rocket, y_rocket  out  10 each  rocket centre, consumed by asteroid hit detection.
REQ-011 rocket_active  out  1  rocket in flight.
REQ-012 rocket_on  out  1  pixel inside rocket box.
REQ-013 rgb_rocket  out  12  constant 12'h0F0.
REQ-014 shots_fired  out  8  launch count.

Function
REQ-015 fire_btn SHALL pass a 2-flop synchronizer on clk before any other use.
REQ-016 Debounced level SHALL change only after the synchronized input differs from it on DEBOUNCE consecutive ticks; any disagreement-free break restarts the count.
REQ-017 A fire request SHALL be a debounced 0->1 transition; requests are never queued.
REQ-018 FSM states: IDLE, FLYING, COOLDOWN; transitions occur only on clk edges with tick_1ms=1, except REQ-023.
REQ-019 IDLE->FLYING on a fire request when game_state==01: x_rocket<=x_ship+33, y_rocket<=y_ship, shots_fired+1 (saturating at 255); otherwise request discarded.
REQ-020 FLYING, each tick: if hit=1 -> COOLDOWN; else if x_rocket+SPEED>=632 -> COOLDOWN; else x_rocket<=x_rocket+SPEED, y_rocket held.
REQ-021 hit and off-screen on same tick SHALL both resolve to COOLDOWN (hit priority, identical outcome).
REQ-022 COOLDOWN SHALL last exactly COOLDOWN ticks, then IDLE; fire requests during FLYING or COOLDOWN are discarded.
REQ-023 game_state!=01 in any state SHALL force IDLE and park on the next clk edge, without waiting for tick; cooldown count cleared.
REQ-024 Outside FLYING, x_rocket=0, y_rocket=0 (parked outside asteroid path); rocket_active=1 only in FLYING.
REQ-025 hit in IDLE or COOLDOWN SHALL be ignored.
REQ-026 rocket_on SHALL be combinational: rocket_active and x in [x_rocket-8, x_rocket+8] and y in [y_rocket-8, y_rocket+8], evaluated with 11-bit arithmetic so no wrap at y_rocket<8.
REQ-027 Launch x computation SHALL be 10-bit; x_ship+33>=632 launches directly to COOLDOWN on the next tick.

Reset
REQ-028 reset SHALL set: state IDLE, x_rocket=0, y_rocket=0, rocket_active=0, shots_fired=0, debounced level=0, debounce and cooldown counters=0, synchronizer flops=0.
REQ-029 reset mid-flight SHALL take effect on that clk edge regardless of tick_1ms.

Structure
REQ-030 Shared package game_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, ship 50x20, rocket 16x16, game_state encodings; FSM state enum stays local.
REQ-031 Synchronizer+debounce SHALL be one sub-module, btn_debounce, outputting level and rise pulse.

Verification
REQ-032 Press 12 ticks, game_state=01, ship (80,240) -> launch at (113,240), shots_fired=1, x_rocket +4 per tick.
REQ-033 Button bounce toggling every 3 ticks for 30 ticks -> no launch.
REQ-034 hit asserted at x_rocket=305 -> COOLDOWN, parked (0,0); fire 100 ticks later discarded; fire after 250 ticks launches.
REQ-035 Uninterrupted flight from 113 -> retires when x_rocket+4>=632 (at x_rocket=629), hit and edge simultaneously tested -> COOLDOWN once.
REQ-036 game_state 01->10 mid-flight between ticks -> IDLE, parked next clk; reset during FLYING -> all REQ-028 values next clk.
